// File: rtl/iq_freelist_ctrl.sv
// iq_freelist_ctrl: pointer/count controller for the issue-queue free list.
// Latency: alloc IDs and RAM write ports are combinational; freeCount_o/iqFull_o/ready_o come from registered state.
// Backpressure: none; an over-allocation or over-free is dropped and raises sticky err_o.
// Option: define IQ_FREELIST_PART_EN to size the active list from partActive_i.
module iq_freelist_ctrl #(
  parameter int IQ_DEPTH   = 32,
  parameter int IQ_INDEX   = 5,
  parameter int DISP_WIDTH = 4,
  parameter int FREE_WIDTH = 4,
  parameter int NUM_PARTS  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic [$clog2(DISP_WIDTH+1)-1:0]  allocCnt_i,
  output logic [DISP_WIDTH*IQ_INDEX-1:0]   rdAddr_o,
  input  logic [DISP_WIDTH*IQ_INDEX-1:0]   rdData_i,
  output logic [DISP_WIDTH*IQ_INDEX-1:0]   allocEntry_o,
  input  logic [FREE_WIDTH-1:0]            freeValid_i,
  input  logic [FREE_WIDTH*IQ_INDEX-1:0]   freeEntry_i,
`ifdef IQ_FREELIST_PART_EN
  input  logic [NUM_PARTS-1:0]             partActive_i,
`endif
  output logic [FREE_WIDTH-1:0]            we_o,
  output logic [FREE_WIDTH*IQ_INDEX-1:0]   wrAddr_o,
  output logic [FREE_WIDTH*IQ_INDEX-1:0]   wrData_o,
  output logic [IQ_INDEX:0]                freeCount_o,
  output logic                             iqFull_o,
  output logic                             ready_o,
  output logic                             err_o
);

  // Wide enough for count - alloc + frees without overflow.
  localparam int CW         = IQ_INDEX + 2;
  localparam int PART_SLOTS = IQ_DEPTH / NUM_PARTS;

  typedef enum logic {INIT, READY} state_t;

  state_t              state, state_n;
  logic [IQ_INDEX-1:0] head, head_n, tail, tail_n;
  logic [IQ_INDEX:0]   init_ptr, init_n, count, count_n;
  logic [IQ_INDEX:0]   depth;
  logic                err_n;

  // Pointer add modulo the active depth; p < d and n <= d, so one subtract suffices.
  function automatic logic [IQ_INDEX-1:0] ptr_add(input logic [IQ_INDEX-1:0] p,
                                                  input logic [CW-1:0] n,
                                                  input logic [IQ_INDEX:0] d);
    return IQ_INDEX'(((CW'(p) + n) >= CW'(d)) ? (CW'(p) + n - CW'(d)) : (CW'(p) + n));
  endfunction

`ifdef IQ_FREELIST_PART_EN
  logic [IQ_INDEX:0] depth_sel;

  // Active depth from the number of enabled partitions (none enabled counts as one).
  always_comb begin
    int np;
    np = 0;
    for (int p = 0; p < NUM_PARTS; p++) np = np + int'(partActive_i[p]);
    if (np == 0) np = 1;
    depth_sel = (IQ_INDEX+1)'(np * PART_SLOTS);
  end

  // Depth is captured only when the list (re)enters INIT.
  always_ff @(posedge clk) begin
    if (reset || flush_i) depth <= depth_sel;
  end
`else
  assign depth = (IQ_INDEX+1)'(NUM_PARTS * PART_SLOTS);
`endif

  assign allocEntry_o = rdData_i;
  assign freeCount_o  = count;
  assign ready_o      = (state == READY);
  assign iqFull_o     = (state != READY) || (count < (IQ_INDEX+1)'(DISP_WIDTH));

  // Read lanes always present the next DISP_WIDTH slots after head.
  always_comb begin
    rdAddr_o = '0;
    for (int i = 0; i < DISP_WIDTH; i++)
      rdAddr_o[i*IQ_INDEX +: IQ_INDEX] = ptr_add(head, CW'(i), depth);
  end

  // Next-state, pointer/count update and RAM write port generation.
  always_comb begin
    logic [CW-1:0] n_free;
    logic [CW-1:0] n_alloc;
    logic [CW-1:0] cnt_after;
    int            wr_idx;
    state_n   = state;
    head_n    = head;
    tail_n    = tail;
    init_n    = init_ptr;
    count_n   = count;
    err_n     = err_o;
    we_o      = '0;
    wrAddr_o  = '0;
    wrData_o  = '0;
    n_free    = '0;
    n_alloc   = CW'(allocCnt_i);
    cnt_after = '0;
    wr_idx    = 0;
    for (int k = 0; k < FREE_WIDTH; k++) n_free = n_free + CW'(freeValid_i[k]);

    if (flush_i) begin
      state_n = INIT;
      head_n  = '0;
      tail_n  = '0;
      init_n  = '0;
      count_n = '0;
    end else if (state == INIT) begin
      for (int k = 0; k < FREE_WIDTH; k++) begin
        we_o[k]                          = 1'b1;
        wrAddr_o[k*IQ_INDEX +: IQ_INDEX] = IQ_INDEX'(init_ptr + (IQ_INDEX+1)'(k));
        wrData_o[k*IQ_INDEX +: IQ_INDEX] = IQ_INDEX'(init_ptr + (IQ_INDEX+1)'(k));
      end
      init_n = init_ptr + (IQ_INDEX+1)'(FREE_WIDTH);
      if (init_n >= depth) begin
        state_n = READY;
        count_n = depth;
      end
    end else begin
      // Allocation beyond the free count is dropped entirely.
      if (n_alloc > CW'(count)) begin
        err_n   = 1'b1;
        n_alloc = '0;
      end
      cnt_after = CW'(count) - n_alloc + n_free;
      if (cnt_after > CW'(depth)) begin
        // Over-free: no writes, frees do not touch tail or count.
        err_n     = 1'b1;
        cnt_after = CW'(count) - n_alloc;
      end else begin
        for (int k = 0; k < FREE_WIDTH; k++) begin
          if (freeValid_i[k]) begin
            we_o[wr_idx]                          = 1'b1;
            wrAddr_o[wr_idx*IQ_INDEX +: IQ_INDEX] = ptr_add(tail, CW'(wr_idx), depth);
            wrData_o[wr_idx*IQ_INDEX +: IQ_INDEX] = freeEntry_i[k*IQ_INDEX +: IQ_INDEX];
            wr_idx = wr_idx + 1;
          end
        end
        tail_n = ptr_add(tail, n_free, depth);
      end
      head_n  = ptr_add(head, n_alloc, depth);
      count_n = (IQ_INDEX+1)'(cnt_after);
    end
  end

  // State register; err_o survives flush and clears only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      head     <= '0;
      tail     <= '0;
      init_ptr <= '0;
      count    <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_n;
      head     <= head_n;
      tail     <= tail_n;
      init_ptr <= init_n;
      count    <= count_n;
      err_o    <= err_n;
    end
  end

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// tb_iq_freelist_ctrl: self-checking bench for iq_freelist_ctrl (default build, D = 32).
// Latency: drives inputs 1 time unit after posedge, samples on negedge.
// Backpressure: bench models the free-list RAM with combinational read.
module tb_iq_freelist_ctrl;
  localparam int W = 5, DW = 4, FW = 4, DEP = 32;

  logic          clk = 1'b0;
  logic          reset, flush_i;
  logic [2:0]    allocCnt_i;
  logic [DW*W-1:0] rdAddr_o, rdData_i, allocEntry_o;
  logic [FW-1:0] freeValid_i, we_o;
  logic [FW*W-1:0] freeEntry_i, wrAddr_o, wrData_o;
  logic [W:0]    freeCount_o;
  logic          iqFull_o, ready_o, err_o;

  always #5 clk = ~clk;

  iq_freelist_ctrl dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .allocCnt_i(allocCnt_i),
    .rdAddr_o(rdAddr_o), .rdData_i(rdData_i), .allocEntry_o(allocEntry_o),
    .freeValid_i(freeValid_i), .freeEntry_i(freeEntry_i), .we_o(we_o),
    .wrAddr_o(wrAddr_o), .wrData_o(wrData_o), .freeCount_o(freeCount_o),
    .iqFull_o(iqFull_o), .ready_o(ready_o), .err_o(err_o)
  );

  // Free-list RAM: combinational read, clocked write.
  logic [W-1:0] ram [DEP];
  always_comb begin
    rdData_i = '0;
    for (int i = 0; i < DW; i++) rdData_i[i*W +: W] = ram[rdAddr_o[i*W +: W]];
  end
  always @(posedge clk) begin
    for (int k = 0; k < FW; k++)
      if (we_o[k]) ram[wrAddr_o[k*W +: W]] <= wrData_o[k*W +: W];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  function automatic int lane(input logic [19:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  // Reference model: free IDs as an ordered queue, allocated IDs as a pool.
  int q[$];
  int inuse[$];
  bit m_ready, m_err;
  int m_init;

  task automatic model_reset();
    q.delete();
    inuse.delete();
    m_ready = 1'b0;
    m_init  = DEP / FW;
  endtask

  task automatic model_step(input bit fl, input int a, input logic [3:0] fv, input logic [19:0] fe);
    int nf;
    if (fl) begin
      model_reset();
      return;
    end
    if (!m_ready) begin
      m_init--;
      if (m_init == 0) begin
        m_ready = 1'b1;
        for (int j = 0; j < DEP; j++) q.push_back(j);
      end
      return;
    end
    if (a > q.size()) begin
      m_err = 1'b1;
      a = 0;
    end
    nf = $countones(fv);
    if (q.size() - a + nf > DEP) begin
      m_err = 1'b1;
      nf = 0;
    end
    for (int i = 0; i < a; i++) inuse.push_back(q.pop_front());
    if (nf > 0)
      for (int k = 0; k < FW; k++) if (fv[k]) q.push_back(lane(fe, k));
  endtask

  typedef struct {
    logic [2:0]  alloc;
    logic [3:0]  fv;
    logic [19:0] fe;
    logic [19:0] rd;
    logic [19:0] ae;
    logic [3:0]  we;
    logic [19:0] wa;
    logic [19:0] wd;
    int          cnt;
    logic        full;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int h, lim;
    // Directed sequence after init: head/tail walk, wrap, over-alloc, sticky err.
    tbl[0] = '{3'd4, 4'h0, 20'd0, p4(0,1,2,3), p4(0,1,2,3), 4'h0, 20'd0, 20'd0, 32, 1'b0, 1'b0};
    tbl[1] = '{3'd3, 4'b1010, p4(0,9,0,2), p4(4,5,6,7), p4(4,5,6,7), 4'b0011, p4(0,1,0,0), p4(9,2,0,0), 28, 1'b0, 1'b0};
    h = 7;
    for (int r = 2; r <= 6; r++) begin
      tbl[r] = '{3'd4, 4'h0, 20'd0, p4(h,h+1,h+2,h+3), p4(h,h+1,h+2,h+3), 4'h0, 20'd0, 20'd0, 27-4*(r-2), 1'b0, 1'b0};
      h += 4;
    end
    tbl[7]  = '{3'd3, 4'h0, 20'd0, p4(27,28,29,30), p4(27,28,29,30), 4'h0, 20'd0, 20'd0, 7, 1'b0, 1'b0};
    tbl[8]  = '{3'd4, 4'h0, 20'd0, p4(30,31,0,1), p4(30,31,9,2), 4'h0, 20'd0, 20'd0, 4, 1'b0, 1'b0};
    tbl[9]  = '{3'd0, 4'hf, p4(4,5,6,7), p4(2,3,4,5), 20'd0, 4'hf, p4(2,3,4,5), p4(4,5,6,7), 0, 1'b1, 1'b0};
    tbl[10] = '{3'd2, 4'h0, 20'd0, p4(2,3,4,5), p4(4,5,6,7), 4'h0, 20'd0, 20'd0, 4, 1'b0, 1'b0};
    tbl[11] = '{3'd3, 4'h0, 20'd0, p4(4,5,6,7), p4(6,7,0,0), 4'h0, 20'd0, 20'd0, 2, 1'b1, 1'b0};
    tbl[12] = '{3'd0, 4'h0, 20'd0, p4(4,5,6,7), p4(6,7,0,0), 4'h0, 20'd0, 20'd0, 2, 1'b1, 1'b1};
    tbl[13] = '{3'd0, 4'b0001, p4(8,0,0,0), p4(4,5,6,7), p4(6,7,0,0), 4'b0001, p4(6,0,0,0), p4(8,0,0,0), 2, 1'b1, 1'b1};
    tbl[14] = '{3'd1, 4'h0, 20'd0, p4(4,5,6,7), p4(6,7,8,0), 4'h0, 20'd0, 20'd0, 3, 1'b1, 1'b1};

    reset = 1'b1; flush_i = 1'b0; allocCnt_i = '0; freeValid_i = '0; freeEntry_i = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Reset state and the 8 INIT write cycles.
    @(negedge clk);
    chk("reset_ready", ready_o, 0);
    chk("reset_full", iqFull_o, 1);
    chk("reset_cnt", freeCount_o, 0);
    chk("reset_err", err_o, 0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      chk("init_we", we_o, 4'hf);
      chk("init_wa", wrAddr_o, p4(4*c, 4*c+1, 4*c+2, 4*c+3));
      chk("init_wd", wrData_o, p4(4*c, 4*c+1, 4*c+2, 4*c+3));
      chk("init_ready", ready_o, 0);
      @(posedge clk); #1;
    end

    for (int r = 0; r < 15; r++) begin
      allocCnt_i = tbl[r].alloc; freeValid_i = tbl[r].fv; freeEntry_i = tbl[r].fe;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), ready_o, 1);
      chk($sformatf("tbl%0d_cnt", r), freeCount_o, tbl[r].cnt);
      chk($sformatf("tbl%0d_full", r), iqFull_o, tbl[r].full);
      chk($sformatf("tbl%0d_err", r), err_o, tbl[r].err);
      chk($sformatf("tbl%0d_rd", r), rdAddr_o, tbl[r].rd);
      chk($sformatf("tbl%0d_we", r), we_o, tbl[r].we);
      lim = (tbl[r].cnt < 4) ? tbl[r].cnt : 4;
      for (int i = 0; i < lim; i++)
        chk($sformatf("tbl%0d_ae%0d", r, i), lane(allocEntry_o, i), lane(tbl[r].ae, i));
      for (int i = 0; i < FW; i++) if (tbl[r].we[i]) begin
        chk($sformatf("tbl%0d_wa%0d", r, i), lane(wrAddr_o, i), lane(tbl[r].wa, i));
        chk($sformatf("tbl%0d_wd%0d", r, i), lane(wrData_o, i), lane(tbl[r].wd, i));
      end
      @(posedge clk); #1;
    end

    // Flush with a concurrent alloc, then flush again mid-INIT.
    freeValid_i = '0; allocCnt_i = 3'd4; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_cyc_ready", ready_o, 1);
    @(posedge clk); #1 flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_ready", ready_o, 0);
      chk("flush_cnt", freeCount_o, 0);
      chk("flush_full", iqFull_o, 1);
      chk("flush_err_kept", err_o, 1);
      chk("flush_wa", wrAddr_o, p4(4*c, 4*c+1, 4*c+2, 4*c+3));
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("reinit_we", we_o, 4'hf);
      chk("reinit_wa", wrAddr_o, p4(4*c, 4*c+1, 4*c+2, 4*c+3));
      @(posedge clk); #1;
    end

    // Over-free with a full list: writes suppressed, count unchanged.
    allocCnt_i = '0; freeValid_i = 4'b0001; freeEntry_i = p4(3,0,0,0);
    @(negedge clk);
    chk("full_ready", ready_o, 1);
    chk("full_cnt", freeCount_o, 32);
    chk("overfree_we", we_o, 0);
    @(posedge clk); #1 freeValid_i = '0; allocCnt_i = 3'd4;
    @(negedge clk);
    chk("overfree_cnt", freeCount_o, 32);
    chk("overfree_err", err_o, 1);
    chk("reinit_ae", allocEntry_o, p4(0,1,2,3));
    @(posedge clk); #1 allocCnt_i = '0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_err_clr", err_o, 0);
    chk("reset_cnt2", freeCount_o, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    m_err = 1'b0;

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      int a, nf, idx, id, sz;
      bit fl;
      logic [3:0] fv;
      logic [19:0] fe;
      fl = ($urandom_range(0, 79) == 0);
      fv = '0; fe = '0;
      sz = q.size();
      if (m_ready) begin
        if (sz < 4 && $urandom_range(0, 15) == 0) a = sz + 1;
        else a = $urandom_range(0, (sz < 4) ? sz : 4);
        for (int k = 0; k < FW; k++) begin
          if (inuse.size() > 0 && $urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, inuse.size() - 1);
            id  = inuse[idx];
            inuse.delete(idx);
            fv[k] = 1'b1;
            fe[k*W +: W] = id[4:0];
          end
        end
      end else begin
        a  = $urandom_range(0, 4);
        fv = 4'($urandom);
        fe = 20'($urandom);
      end
      nf = $countones(fv);
      flush_i = fl; allocCnt_i = 3'(a); freeValid_i = fv; freeEntry_i = fe;
      @(negedge clk);
      chk("rnd_cnt", freeCount_o, m_ready ? sz : 0);
      chk("rnd_ready", ready_o, m_ready);
      chk("rnd_full", iqFull_o, (!m_ready || sz < 4));
      chk("rnd_err", err_o, m_err);
      if (m_ready) begin
        for (int i = 0; i < ((sz < 4) ? sz : 4); i++)
          chk("rnd_ae", lane(allocEntry_o, i), q[i]);
        if (!fl) chk("rnd_we", we_o, (1 << nf) - 1);
      end else if (!fl) begin
        chk("rnd_init_we", we_o, 4'hf);
      end
      @(posedge clk);
      model_step(fl, a, fv, fe);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
